// File: rtl/regfile_mp_sb.sv
// Multi-port register file with same-cycle write-to-read forwarding and an
// integrated busy-bit scoreboard for the decode/issue stage; r0 reads as zero.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  flush,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ADDR_W:0]     busy_cnt_q;
  logic [ADDR_W:0]     busy_cnt_d;

  // Storage update: ascending port order lets the highest-index port win
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] != '0))
          regs_q[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read ports: forwarding from the write ports also masks the busy bit
  always_comb begin : rd_comb
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    logic              hit;
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    val   = '0;
    hit   = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      ra  = raddr[j*ADDR_W +: ADDR_W];
      val = regs_q[ra];
      hit = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == ra)) begin
          hit = 1'b1;
          val = wdata[i*DATA_W +: DATA_W];
        end
      end
      if (!rst && re[j] && (ra != '0)) begin
        rdata[j*DATA_W +: DATA_W] = val;
        rbusy[j]                  = busy_q[ra] & ~hit;
      end
    end
  end

  // Scoreboard next state: writeback clears, then the younger alloc sets
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWR; i++) begin
      if (we[i]) busy_d[waddr[i*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (alloc_en) busy_d[alloc_addr] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;

    busy_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++)
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the decode stage of the next core.
- Provides NRD combinational read ports and NWR write ports, with same-cycle write-to-read forwarding.
- Includes an integrated scoreboard: a busy bit per register is set when an instruction that writes that register issues, and cleared at writeback or flush.
- Sits between decode/issue (read, alloc, stall decision) and writeback (write ports); register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; port index NWR-1 has highest priority.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- we  in  NWR  per-port write enable.
- waddr  in  NWR*ADDR_W  write addresses; port i at bits [i*ADDR_W +: ADDR_W].
- wdata  in  NWR*DATA_W  write data, same packing.
- re  in  NRD  per-port read enable.
- raddr  in  NRD*ADDR_W  read addresses, same packing.
- rdata  out  NRD*DATA_W  read data, combinational.
- rbusy  out  NRD  read register has a pending producer, combinational.
- alloc_en  in  1  issue of an instruction that writes alloc_addr.
- alloc_addr  in  ADDR_W  destination being allocated.
- flush  in  1  squash all pending allocations.
- busy_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:

Storage:
- regs[NUM_REGS] and busy[NUM_REGS] are flops.
- Synchronous rst clears all regs to 0, all busy bits to 0, and busy_cnt to 0 on the next clk edge.
- While rst is high: rdata = 0 and rbusy = 0 on all ports, and writes/allocs are ignored.

Write:
- On the posedge, for each port i with we[i]=1 and waddr[i]!=0: regs[waddr[i]] <= wdata[i].
- If several ports target the same address in one cycle, the highest-index port wins.
- Writes to address 0 are dropped.
- Write gating depends only on address and enable, never on data value; writing 0 to a nonzero register is legal.

Read, per port j (combinational, zero latency), evaluated in priority order:
- rst → rdata 0.
- re[j]=0 → rdata 0.
- raddr[j]=0 → rdata 0.
- Any we[i] with waddr[i]==raddr[j] → rdata = wdata of the highest such i (forwarding).
- Otherwise → rdata = regs[raddr[j]].

rbusy[j]:
- rbusy[j] = re[j] & (raddr[j]!=0) & busy[raddr[j]] & ~(any we[i] with waddr[i]==raddr[j]).
- A same-cycle writeback therefore hides the busy bit.
- alloc_en in the same cycle is not visible in rbusy until the next cycle.

Scoreboard update at posedge, in priority order:
- rst → busy cleared.
- flush → all busy bits cleared, including any same-cycle alloc (flush wins).
- Otherwise, for each register r: next busy[r] = (alloc_en & alloc_addr==r & r!=0) | (busy[r] & ~clear[r]), where clear[r] = any we[i] with waddr[i]==r.
- Alloc and writeback to the same register in the same cycle → busy ends set (alloc is younger).
- Alloc of an already-busy register stays busy; there is no count of outstanding writes.
- busy[0] is always 0.

busy_cnt:
- Registered popcount of next-state busy, updated on the same edge as busy.
- Range 0..NUM_REGS-1.
- 0 after rst and after flush.

Reset mid-operation:
- Reset takes effect on the next edge regardless of pending writes or allocs.
- Register contents are not preserved.

Test Plan:
- Reset then read: after rst, re=2'b11, raddr={5'd3,5'd0} → rdata both 0, rbusy 0, busy_cnt 0.
- Write and forward: cycle N we[0]=1, waddr=7, wdata=32'hDEADBEEF, raddr0=7 → rdata0=DEADBEEF the same cycle. Cycle N+1 with we=0 → rdata0=DEADBEEF from storage. Writing 32'h0 to r7 next → read returns 0.
- Port conflict: we=2'b11, both waddr=9, wdata0=32'h11, wdata1=32'h22 → forwarded rdata=32'h22, and stored r9=32'h22.
- Scoreboard: alloc r5 in cycle N → rbusy for r5 is 0 in N, 1 in N+1, busy_cnt=1. Writeback r5 in N+3 → rbusy=0 in N+3, busy_cnt=0 after.
- Alloc + writeback same cycle: r5 busy, we r5 and alloc r5 together → busy remains 1, busy_cnt unchanged. Alloc of r0 → busy_cnt stays 0.
- Flush: alloc r1, r2, r3 over three cycles (busy_cnt=3), then flush together with alloc r4 → next cycle all busy 0, busy_cnt 0. A concurrent write to r2 still lands.
